reg_file_mp: RTL and testbench

Parametrised multi-port register file for the pipelined core, replacing the fixed 32x32, 2-read/1-write file.
- Configurable word width, register count and number of read ports.
- Two write ports: W0 for the main writeback, W1 for the late/memory writeback.
- Per-register busy scoreboard, consulted by the hazard unit at decode.
- Sits between ID (reads, scoreboard set) and WB (writes, scoreboard clear).

---
 rtl/reg_file_mp.sv | 65 ++++++
 tb/tb_reg_file_mp.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with busy scoreboard (async active-low rst; rd_addr/rd_data/rd_busy packed per read port; wr0/wr1 write ports, W1 wins; sb_set_en/sb_set_addr/sb_flush scoreboard; define REG_FILE_BYPASS_EN for write-to-read forwarding)
module reg_file_mp #(
  parameter int WORD_LEN = 32,
  parameter int REG_CNT  = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_LEN-1:0]   rd_addr,
  output logic [NUM_RD*WORD_LEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr0_en,
  input  logic [ADDR_LEN-1:0]          wr0_addr,
  input  logic [WORD_LEN-1:0]          wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_LEN-1:0]          wr1_addr,
  input  logic [WORD_LEN-1:0]          wr1_data,
  input  logic                         sb_set_en,
  input  logic [ADDR_LEN-1:0]          sb_set_addr,
  input  logic                         sb_flush
);
  logic [WORD_LEN-1:0] mem [REG_CNT];
  logic [REG_CNT-1:0]  busy, busy_nxt;
  logic                we0, we1;
  assign we0 = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign we1 = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);
  always_comb begin
    busy_nxt = busy;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (sb_set_en) busy_nxt[sb_set_addr] = 1'b1;
    if (sb_flush) busy_nxt = '0;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (we0) mem[wr0_addr] <= wr0_data;
      if (we1) mem[wr1_addr] <= wr1_data;
      busy <= busy_nxt;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_LEN-1:0] a;
    logic [WORD_LEN-1:0] d;
    logic                b;
    assign a = rd_addr[k*ADDR_LEN +: ADDR_LEN];
`ifdef REG_FILE_BYPASS_EN
    logic h0, h1;
    assign h0 = we0 && wr0_addr == a;
    assign h1 = we1 && wr1_addr == a;
    assign d  = h1 ? wr1_data : h0 ? wr0_data : mem[a];
    assign b  = busy[a] && !((h0 || h1) && !(sb_set_en && sb_set_addr == a));
`else
    assign d  = mem[a];
    assign b  = busy[a];
`endif
    assign rd_data[k*WORD_LEN +: WORD_LEN] = rst ? d : '0;
    assign rd_busy[k] = rst & b;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks of reg_file_mp against an array-based reference model
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, sb_set_en, sb_flush;
  logic [4:0]  wr0_addr, wr1_addr, sb_set_addr;
  logic [31:0] wr0_data, wr1_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] mm [32];
  logic        mb [32];

  reg_file_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (a != 0 && wr1_en && wr1_addr == a) return wr1_data;
    if (a != 0 && wr0_en && wr0_addr == a) return wr0_data;
`endif
    return mm[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)) && !(sb_set_en && sb_set_addr == a)) return 1'b0;
`endif
    return mb[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mm[r] = '0;
      mb[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int r = 0; r < 32; r++)
      mb[r] = sb_flush ? 1'b0 :
              (sb_set_en && sb_set_addr == r && r != 0) ? 1'b1 :
              ((wr0_en && wr0_addr == r) || (wr1_en && wr1_addr == r)) ? 1'b0 : mb[r];
    if (wr0_en && wr0_addr != 0) mm[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0) mm[wr1_addr] = wr1_data;
  endtask

  task automatic step(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic se, input logic [4:0] sa, input logic fl,
                      input logic [4:0] r0, input logic [4:0] r1);
    wr0_en = e0; wr0_addr = a0; wr0_data = d0;
    wr1_en = e1; wr1_addr = a1; wr1_data = d1;
    sb_set_en = se; sb_set_addr = sa; sb_flush = fl;
    rd_addr = {r1, r0};
    #2;
    check("rd_data0", rd_data[31:0], exp_data(r0));
    check("rd_data1", rd_data[63:32], exp_data(r1));
    check("rd_busy0", {31'b0, rd_busy[0]}, {31'b0, exp_busy(r0)});
    check("rd_busy1", {31'b0, rd_busy[1]}, {31'b0, exp_busy(r1)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] d, input logic b);
    wr0_en = 0; wr1_en = 0; sb_set_en = 0; sb_flush = 0;
    rd_addr = {a, a};
    #2;
    check({tag, "_data"}, rd_data[31:0], d);
    check({tag, "_busy"}, {31'b0, rd_busy[0]}, {31'b0, b});
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    sb_set_en = 0; sb_set_addr = 0; sb_flush = 0; rd_addr = 0;
    model_reset();
    #12;
    check("reset_data", rd_data[31:0], 32'h0);
    check("reset_busy", {30'b0, rd_busy}, 32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 0, 5, 5);
    peek("r5_pre", 5, 32'hDEADBEEF, 1'b1);
    rd_addr = {5'd5, 5'd5};
    #1 rst = 0;
    #1;
    check("async_rst_data", rd_data[31:0], 32'h0);
    check("async_rst_busy", {30'b0, rd_busy}, 32'h0);
    model_reset();
    #1 rst = 1;
    @(negedge clk);
    peek("r5_post", 5, 32'h0, 1'b0);
    step(1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    peek("r3", 3, 32'h12345678, 1'b0);
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0);
    peek("r0", 0, 32'h0, 1'b0);
    step(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 0, 7, 7);
    peek("r7", 7, 32'h2, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 9);
    peek("r9_set", 9, 32'h0, 1'b1);
    step(0, 0, 0, 1, 9, 32'hAA, 1, 9, 0, 9, 9);
    peek("r9_setwin", 9, 32'hAA, 1'b1);
    step(1, 9, 32'hBB, 0, 0, 0, 0, 0, 0, 9, 9);
    peek("r9_clr", 9, 32'hBB, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 2, 4);
    peek("r4_set", 4, 32'h0, 1'b1);
    step(1, 11, 32'h5A5A, 0, 0, 0, 1, 6, 1, 1, 6);
    peek("r6_flush", 6, 32'h0, 1'b0);
    peek("r2_flush", 2, 32'h0, 1'b0);
    peek("r11_flushwr", 11, 32'h5A5A, 1'b0);
    step(1, 10, 32'hCAFE, 0, 0, 0, 0, 0, 0, 10, 10);
    peek("r10", 10, 32'hCAFE, 1'b0);
    step(1, 10, 32'h1111, 1, 10, 32'h2222, 0, 0, 0, 10, 4);
    peek("r10_w1", 10, 32'h2222, 1'b0);
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a0, a1, sa, r0, r1;
      a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
      sa = 5'($urandom_range(0, 7)); r0 = 5'($urandom_range(0, 7));
      r1 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
           1'($urandom), sa, ($urandom % 16 == 0), r0, r1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
